tx_8b10b_framer: RTL and testbench



---
 rtl/line8b10b_pkg.sv | 17 +
 rtl/tx_8b10b_framer_if.sv | 24 ++
 rtl/crc8_byte.sv | 25 ++
 rtl/tx_8b10b_framer.sv | 150 +++++++++++++++
 tb/tb_tx_8b10b_framer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/line8b10b_pkg.sv
// Shared constants and types for the 8B/10B transmit framer.
// K-codes, framer state encoding and the CRC-8 polynomial.
package line8b10b_pkg;

    localparam logic [7:0] K28_5     = 8'hBC;
    localparam logic [7:0] K27_7     = 8'hFB;
    localparam logic [7:0] K29_7     = 8'hFD;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CRC,
        EOF
    } state_e;

endpackage

// File: rtl/tx_8b10b_framer_if.sv
// Byte-stream handshake bundle feeding the framer.
// tdata/tvalid/tlast from source, tready back from framer.
interface tx_8b10b_framer_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/crc8_byte.sv
// Combinational one-byte CRC-8 step (poly 0x07, MSB-first).
// Ports: crc_in, data -> crc_out.
module crc8_byte
    import line8b10b_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/tx_8b10b_framer.sv
// Byte stream -> per-clock 8B/10B character stream with SOF/EOF framing.
// Ports: i_clk, i_reset (sync, high), i_tdata/i_tvalid/i_tlast/o_tready
// byte handshake, o_data/o_datak encoder character, o_busy, o_underrun.
// Optional CRC-8 trailer byte: define TX_8B10B_FRAMER_CRC8_EN.
module tx_8b10b_framer
    import line8b10b_pkg::*;
#(
    parameter int ALIGN_INTERVAL = 64,
    parameter int MIN_IFG        = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_tdata,
    input  logic       i_tvalid,
    input  logic       i_tlast,
    output logic       o_tready,
    output logic [7:0] o_data,
    output logic       o_datak,
    output logic       o_busy,
    output logic       o_underrun
);

    localparam int AW = $clog2(ALIGN_INTERVAL + 1);
    localparam int IW = (MIN_IFG > 0) ? $clog2(MIN_IFG + 1) : 1;

    state_e        state_q, state_d;
    logic [AW-1:0] align_cnt_q, align_cnt_d;
    logic [IW-1:0] ifg_cnt_q, ifg_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          datak_q, datak_d;
    logic          busy_q, busy_d;
    logic          underrun_q, underrun_d;
    logic          align_due;
    logic          is_comma;

`ifdef TX_8B10B_FRAMER_CRC8_EN
    logic [7:0] crc_q, crc_d, crc_next;

    crc8_byte u_crc (
        .crc_in  (crc_q),
        .data    (i_tdata),
        .crc_out (crc_next)
    );
`endif

    assign align_due = (align_cnt_q == AW'(ALIGN_INTERVAL));
    assign o_tready  = (state_q == DATA) && !align_due;

    always_comb begin
        state_d    = state_q;
        ifg_cnt_d  = ifg_cnt_q;
        data_d     = K28_5;
        datak_d    = 1'b1;
        busy_d     = 1'b0;
        underrun_d = 1'b0;
`ifdef TX_8B10B_FRAMER_CRC8_EN
        crc_d      = crc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (ifg_cnt_q != '0) begin
                    ifg_cnt_d = ifg_cnt_q - IW'(1);
                end else if (i_tvalid) begin
                    data_d  = K27_7;
                    busy_d  = 1'b1;
                    state_d = DATA;
`ifdef TX_8B10B_FRAMER_CRC8_EN
                    crc_d   = 8'h00;
`endif
                end
            end
            DATA: begin
                busy_d = 1'b1;
                if (align_due) begin
                    // forced comma: byte stays on the bus
                end else if (i_tvalid) begin
                    data_d  = i_tdata;
                    datak_d = 1'b0;
`ifdef TX_8B10B_FRAMER_CRC8_EN
                    crc_d   = crc_next;
                    if (i_tlast) state_d = CRC;
`else
                    if (i_tlast) state_d = EOF;
`endif
                end else begin
                    underrun_d = 1'b1;
                end
            end
`ifdef TX_8B10B_FRAMER_CRC8_EN
            CRC: begin
                data_d  = crc_q;
                datak_d = 1'b0;
                busy_d  = 1'b1;
                state_d = EOF;
            end
`endif
            EOF: begin
                data_d    = K29_7;
                busy_d    = 1'b1;
                ifg_cnt_d = IW'(MIN_IFG);
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // run length of non-comma characters for receiver alignment
        is_comma = datak_d && (data_d == K28_5);
        if (is_comma) begin
            align_cnt_d = '0;
        end else if (align_due) begin
            align_cnt_d = align_cnt_q;
        end else begin
            align_cnt_d = align_cnt_q + AW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            align_cnt_q <= '0;
            ifg_cnt_q   <= '0;
            data_q      <= K28_5;
            datak_q     <= 1'b1;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef TX_8B10B_FRAMER_CRC8_EN
            crc_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            align_cnt_q <= align_cnt_d;
            ifg_cnt_q   <= ifg_cnt_d;
            data_q      <= data_d;
            datak_q     <= datak_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
`ifdef TX_8B10B_FRAMER_CRC8_EN
            crc_q       <= crc_d;
`endif
        end
    end

    assign o_data     = data_q;
    assign o_datak    = datak_q;
    assign o_busy     = busy_q;
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_tx_8b10b_framer.sv
// Self-checking bench for tx_8b10b_framer.
// Stream-level model plus literal frame expectations.
module tb_tx_8b10b_framer;

    localparam int AI  = 4;
    localparam int IFG = 2;
`ifdef TX_8B10B_FRAMER_CRC8_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] o_data;
    logic       o_datak;
    logic       o_busy;
    logic       o_underrun;

    tx_8b10b_framer_if bus ();

    tx_8b10b_framer #(
        .ALIGN_INTERVAL (AI),
        .MIN_IFG        (IFG)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_tdata    (bus.tdata),
        .i_tvalid   (bus.tvalid),
        .i_tlast    (bus.tlast),
        .o_tready   (bus.tready),
        .o_data     (o_data),
        .o_datak    (o_datak),
        .o_busy     (o_busy),
        .o_underrun (o_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // bit-serial CRC-8, poly 0x07, MSB-first
    function automatic logic [7:0] crc_upd(input logic [7:0] c,
                                           input logic [7:0] d);
        logic [7:0] r;
        logic fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    // ---- stream model: phase 0 idle,1 data,2 crc,3 eof ----
    int         m_phase;
    int         m_run;
    int         m_gap;
    logic [7:0] m_crc;
    logic [7:0] e_data;
    logic       e_k, e_busy, e_und;
    bit         m_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_run = 0; m_gap = IFG; m_crc = 8'h00;
            e_data = 8'hBC; e_k = 1'b1; e_busy = 1'b0; e_und = 1'b0;
            m_on = 1'b1;
        end else if (m_on) begin
            e_data = 8'hBC; e_k = 1'b1; e_und = 1'b0;
            e_busy = (m_phase != 0);
            case (m_phase)
                0: if (m_gap >= IFG && bus.tvalid) begin
                    e_data = 8'hFB; e_busy = 1'b1;
                    m_phase = 1; m_crc = 8'h00;
                end
                1: if (m_run < AI && bus.tvalid) begin
                    e_data = bus.tdata; e_k = 1'b0;
                    m_crc = crc_upd(m_crc, bus.tdata);
                    if (bus.tlast) m_phase = CRC_ON ? 2 : 3;
                end else if (m_run < AI) begin
                    e_und = 1'b1;
                end
                2: begin
                    e_data = m_crc; e_k = 1'b0; m_phase = 3;
                end
                default: begin
                    e_data = 8'hFD; m_phase = 0; m_gap = 0;
                end
            endcase
            if (e_k && e_data == 8'hBC) begin
                m_run = 0;
                if (m_gap < IFG) m_gap++;
            end else begin
                m_run++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("data", {24'd0, o_data}, {24'd0, e_data});
            check("datak", {31'd0, o_datak}, {31'd0, e_k});
            check("busy", {31'd0, o_busy}, {31'd0, e_busy});
            check("underrun", {31'd0, o_underrun}, {31'd0, e_und});
            check("tready", {31'd0, bus.tready},
                  {31'd0, (m_phase == 1 && m_run < AI)});
        end
    end

    // ---- frame capture ----
    logic [8:0] cur_q[$];
    logic [8:0] last_q[$];
    int frames_done = 0;
    int und_cnt = 0, last_und = 0;
    int idle_run = 0, last_gap = 0;

    always @(negedge clk) begin
        if (o_busy) begin
            if (cur_q.size() == 0) begin
                last_gap = idle_run;
                idle_run = 0;
            end
            cur_q.push_back({o_datak, o_data});
            if (o_underrun) und_cnt++;
        end else begin
            idle_run++;
            if (cur_q.size() > 0) begin
                last_q = cur_q;
                last_und = und_cnt;
                cur_q.delete();
                und_cnt = 0;
                frames_done++;
            end
        end
    end

    task automatic wait_frame(input int f0);
        int t;
        t = 0;
        while (frames_done == f0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        check("frame_timeout", {31'd0, frames_done > f0}, 32'd1);
        #1;
    endtask

    task automatic expect_frame(input string nm, input logic [8:0] exp[$]);
        check({nm, "_len"}, last_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < last_q.size(); i++)
            check(nm, {23'd0, last_q[i]}, {23'd0, exp[i]});
    endtask

    task automatic send_frame(input logic [7:0] b[$], input int gap_idx);
        logic rdy;
        int t;
        for (int i = 0; i < b.size(); i++) begin
            bus.tdata  = b[i];
            bus.tvalid = 1'b1;
            bus.tlast  = (i == b.size() - 1);
            t = 0;
            do begin
                @(negedge clk);
                rdy = bus.tready;
                @(posedge clk);
                #1;
                t++;
            end while (!rdy && t < 100);
            check("accept_timeout", {31'd0, rdy}, 32'd1);
            if (i == gap_idx) begin
                bus.tvalid = 1'b0;
                bus.tlast  = 1'b1;
                repeat (2) @(posedge clk);
                #1;
            end
        end
        bus.tvalid = 1'b0;
        bus.tlast  = 1'b0;
    endtask

    function automatic void add_trailer(ref logic [8:0] q[$],
                                        input logic [7:0] b[$]);
        logic [7:0] c;
        c = 8'h00;
        foreach (b[i]) c = crc_upd(c, b[i]);
        if (CRC_ON) q.push_back({1'b0, c});
        q.push_back({1'b1, 8'hFD});
    endfunction

    initial begin
        logic [7:0] b[$];
        logic [8:0] x[$];
        int f0, t;

        bus.tdata = 8'h00; bus.tvalid = 1'b0; bus.tlast = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("crc_0102", {24'd0, crc_upd(crc_upd(8'h00, 8'h01), 8'h02)},
              32'h1B);

        repeat (10) begin
            @(negedge clk);
            check("idle_data", {24'd0, o_data}, 32'hBC);
            check("idle_k", {31'd0, o_datak}, 32'd1);
            check("idle_rdy", {31'd0, bus.tready}, 32'd0);
            check("idle_busy", {31'd0, o_busy}, 32'd0);
        end

        // basic three-byte frame
        f0 = frames_done;
        b = '{8'h01, 8'h02, 8'h03};
        send_frame(b, -1);
        wait_frame(f0);
        x = '{9'h1FB, 9'h001, 9'h002, 9'h003};
        if (CRC_ON) x.push_back(9'h048);
        x.push_back(9'h1FD);
        expect_frame("basic", x);

        // ten-byte frame forces alignment commas
        f0 = frames_done;
        b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
        send_frame(b, -1);
        wait_frame(f0);
        check("ifg_gap", {31'd0, last_gap >= IFG}, 32'd1);
        x = '{9'h1FB, 9'h001, 9'h002, 9'h003, 9'h1BC, 9'h004, 9'h005,
              9'h006, 9'h007, 9'h1BC, 9'h008, 9'h009, 9'h00A};
        add_trailer(x, b);
        expect_frame("align", x);
        check("align_und", last_und, 0);

        // source stalls for two cycles mid-frame
        f0 = frames_done;
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(b, 1);
        wait_frame(f0);
        x = '{9'h1FB, 9'h011, 9'h022, 9'h1BC, 9'h1BC, 9'h033, 9'h044};
        add_trailer(x, b);
        expect_frame("underrun", x);
        check("underrun_cnt", last_und, 2);

        // two-byte frame; CRC 0x1B when enabled
        f0 = frames_done;
        b = '{8'h01, 8'h02};
        send_frame(b, -1);
        wait_frame(f0);
        x = '{9'h1FB, 9'h001, 9'h002};
        if (CRC_ON) x.push_back(9'h01B);
        x.push_back(9'h1FD);
        expect_frame("crc", x);

        // reset in the middle of a frame
        bus.tdata = 8'h55; bus.tvalid = 1'b1; bus.tlast = 1'b0;
        t = 0;
        while (!o_busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("busy_timeout", {31'd0, o_busy}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.tvalid = 1'b0;
        @(negedge clk);
        check("rst_data", {24'd0, o_data}, 32'hBC);
        check("rst_k", {31'd0, o_datak}, 32'd1);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        @(posedge clk);
        #1;

        f0 = frames_done;
        b = '{8'hA0, 8'hA1};
        send_frame(b, -1);
        wait_frame(f0);
        x = '{9'h1FB, 9'h0A0, 9'h0A1};
        add_trailer(x, b);
        expect_frame("after_rst", x);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
